// File: rtl/i2c_txn_arbiter_pkg.sv
// rtl/i2c_txn_arbiter_pkg.sv - shared widths, FSM encoding and pointer helper for the I2C transaction arbiter
package i2c_txn_arbiter_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int GRANT_W    = 3;
  localparam int TCNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_COMPLETE   = 3'd4
  } state_e;

  // Round-robin successor of a requester index, wrapping at num_req.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] id, input int num_req);
    if (int'(id) >= num_req - 1) begin
      return '0;
    end
    return id + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - command/handshake bus between the arbiter and the shared I2C master
interface i2c_txn_arbiter_if;
  import i2c_txn_arbiter_pkg::*;

  logic                  m_enable;
  logic [I2C_ADDR_W-1:0] m_addr;
  logic [I2C_DATA_W-1:0] m_data_in;
  logic                  m_rw;
  logic                  m_ready;
  logic                  m_done;
  logic [I2C_DATA_W-1:0] m_data_out;

  // Arbiter side: issues commands, observes master status.
  modport master (
    output m_enable, m_addr, m_data_in, m_rw,
    input  m_ready, m_done, m_data_out
  );

  // Master controller side.
  modport slave (
    input  m_enable, m_addr, m_data_in, m_rw,
    output m_ready, m_done, m_data_out
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// rtl/i2c_txn_arbiter_rr_arbiter.sv - combinational round-robin pick starting at the priority pointer
module i2c_txn_arbiter_rr_arbiter
  import i2c_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GRANT_W-1:0] idx_o,
  output logic               valid_o
);

  logic found;
  int   j;

  // Scan requesters from the pointer upward (wrapping) and take the first one asserted.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = GRANT_W'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharing of one I2C master among several single-byte requesters
module i2c_txn_arbiter
  import i2c_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0]   req_addr_i,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]              req_rw_i,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic                            err_o,
  output logic [I2C_DATA_W-1:0]           rdata_o,
  output logic                            busy_o,
  output logic [GRANT_W-1:0]              grant_id_o,
  i2c_txn_arbiter_if.master               m_bus
);

  localparam logic [TCNT_W-1:0]  TO_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_e                state_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic                  err_q;
  logic [I2C_DATA_W-1:0] rdata_q;
  logic [GRANT_W-1:0]    grant_id_q;
  logic [GRANT_W-1:0]    ptr_q;
  logic [GRANT_W-1:0]    ptr_d;
  logic                  m_enable_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic [I2C_DATA_W-1:0] m_data_q;
  logic                  m_rw_q;
  logic [TCNT_W-1:0]     tcnt_q;
  logic [TCNT_W-1:0]     tcnt_d;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [GRANT_W-1:0]    arb_idx;
  logic                  arb_valid;
  logic [I2C_ADDR_W-1:0] sel_addr;
  logic [I2C_DATA_W-1:0] sel_wdata;
  logic                  sel_rw;

  // A requester whose ack is still on the wire cannot be re-granted in the same cycle
  // (matters after a timeout, which returns straight to IDLE).
  assign elig   = req_i & ~ack_q;
  assign ptr_d  = rr_next(grant_id_q, NUM_REQ);
  assign tcnt_d = tcnt_q + TCNT_W'(1);

  i2c_txn_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // AND-OR mux of the winning requester's command fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = sel_addr  | req_addr_i[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_wdata = sel_wdata | req_wdata_i[i*I2C_DATA_W +: I2C_DATA_W];
        sel_rw    = sel_rw    | req_rw_i[i];
      end
    end
  end

  // Transaction FSM: latch winner, launch master, follow ready/done, pulse ack (or timeout err).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      m_enable_q <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_rw_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid && m_bus.m_ready) begin
            grant_id_q <= arb_idx;
            m_addr_q   <= sel_addr;
            m_data_q   <= sel_wdata;
            m_rw_q     <= sel_rw;
            m_enable_q <= 1'b1;
            tcnt_q     <= '0;
            state_q    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH, ST_WAIT_DONE, ST_WAIT_READY: begin
          if (tcnt_q == TO_LAST) begin
            m_enable_q <= 1'b0;
            ack_q      <= ONE_HOT0 << grant_id_q;
            err_q      <= 1'b1;
            ptr_q      <= ptr_d;
            state_q    <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_d;
            if (state_q == ST_LAUNCH) begin
              if (!m_bus.m_ready) begin
                m_enable_q <= 1'b0;
                state_q    <= ST_WAIT_DONE;
              end
            end else if (state_q == ST_WAIT_DONE) begin
              if (m_bus.m_done) begin
                state_q <= ST_WAIT_READY;
              end
            end else if (m_bus.m_ready) begin
              if (m_rw_q) begin
                rdata_q <= m_bus.m_data_out;
              end
              ack_q   <= ONE_HOT0 << grant_id_q;
              ptr_q   <= ptr_d;
              state_q <= ST_COMPLETE;
            end
          end
        end
        ST_COMPLETE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          m_enable_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o           = ack_q;
  assign err_o           = err_q;
  assign rdata_o         = rdata_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign grant_id_o      = grant_id_q;
  assign m_bus.m_enable  = m_enable_q;
  assign m_bus.m_addr    = m_addr_q;
  assign m_bus.m_data_in = m_data_q;
  assign m_bus.m_rw      = m_rw_q;

endmodule
